// File: rtl/cargador_br.sv
// Run-time loader for the 32x32 register bank: packs a little-endian byte stream
// into 32-bit words and writes them to consecutive registers starting at address 0.
module cargador_br #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [4:0]  Dir,
    output logic [31:0] Di,
    output logic        RegEn,
    output logic        busy,
    output logic        done,
    output logic [5:0]  count
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [4:0] LAST = 5'(NUM_REGS - 1);

    state_t      state, state_nxt;
    logic [4:0]  addr;
    logic [1:0]  byte_idx;
    logic [23:0] word;
    logic        accept;
    logic        load_start;

    assign byte_ready = (state == RECV);
    assign busy       = (state == RECV) || (state == WRITE);
    assign done       = (state == DONE);
    assign accept     = byte_ready && byte_valid;
    assign load_start = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (start) state_nxt = RECV;
                RECV:       if (accept && byte_idx == 2'd3) state_nxt = WRITE;
                WRITE:      state_nxt = (addr == LAST) ? DONE : RECV;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // Bank-facing outputs are registered on the edge that enters WRITE, so they
    // are stable and glitch-free for the whole write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            byte_idx <= '0;
            word     <= '0;
            count    <= '0;
            Dir      <= '0;
            Di       <= '0;
            RegEn    <= 1'b0;
        end else begin
            RegEn <= (state_nxt == WRITE);
            if (abort) begin
                byte_idx <= '0;
            end else if (load_start) begin
                addr     <= '0;
                byte_idx <= '0;
                count    <= '0;
            end else if (accept) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: word[7:0]   <= byte_in;
                    2'd1: word[15:8]  <= byte_in;
                    2'd2: word[23:16] <= byte_in;
                    default: begin
                        Dir <= addr;
                        Di  <= {byte_in, word};
                    end
                endcase
            end
            // A write presented this cycle always completes, even under abort.
            if (state == WRITE) begin
                count <= count + 6'd1;
                if (!abort && addr != LAST) addr <= addr + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_cargador_br.sv
// Directed testbench for cargador_br: full 32-word load plus a 4-register instance.
module tb_cargador_br;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, abort = 1'b0, byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_ready, RegEn, busy, done;
    logic [4:0]  Dir;
    logic [31:0] Di;
    logic [5:0]  count;

    logic        start4 = 1'b0, abort4 = 1'b0, byte_valid4 = 1'b0;
    logic [7:0]  byte_in4 = 8'h00;
    logic        byte_ready4, RegEn4, busy4, done4;
    logic [4:0]  Dir4;
    logic [31:0] Di4;
    logic [5:0]  count4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cargador_br #(.NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .Dir(Dir), .Di(Di), .RegEn(RegEn), .busy(busy), .done(done), .count(count)
    );

    cargador_br #(.NUM_REGS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .byte_in(byte_in4), .byte_valid(byte_valid4), .byte_ready(byte_ready4),
        .Dir(Dir4), .Di(Di4), .RegEn(RegEn4), .busy(busy4), .done(done4), .count(count4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte presented in cycle c of a streaming load (cycle 1 = first RECV cycle).
    function automatic logic [7:0] sbyte(int c);
        return 8'((c / 5) * 4 + (c % 5) - 1);
    endfunction

    function automatic logic [31:0] sword(int n);
        return {8'(4 * n + 3), 8'(4 * n + 2), 8'(4 * n + 1), 8'(4 * n)};
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clean_abort();
        byte_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({byte_ready, RegEn, Dir, Di, busy, done, count} !== 47'd0) begin
            fails++;
            $display("FAIL reset_outputs got %h expected 0", {byte_ready, RegEn, Dir, Di, busy, done, count});
        end
        tests++;
        if ({byte_ready4, RegEn4, Dir4, Di4, busy4, done4, count4} !== 47'd0) begin
            fails++;
            $display("FAIL reset_outputs4 got %h expected 0", {byte_ready4, RegEn4, Dir4, Di4, busy4, done4, count4});
        end
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        tests++;
        if ({byte_ready, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL reset_idle got %b expected 000", {byte_ready, busy, done});
        end
    endtask

    task automatic test_stream();
        logic wr, rdy;
        byte_valid = 1'b1;
        pulse_start();
        for (int c = 1; c <= 161; c++) begin
            wr  = (c % 5 == 0) && (c <= 160);
            rdy = (c % 5 != 0) && (c <= 160);
            tests++;
            if (RegEn !== wr) begin
                fails++;
                $display("FAIL stream_regen c=%0d got %b expected %b", c, RegEn, wr);
            end
            tests++;
            if (byte_ready !== rdy) begin
                fails++;
                $display("FAIL stream_ready c=%0d got %b expected %b", c, byte_ready, rdy);
            end
            if (wr) begin
                tests++;
                if (Dir !== 5'(c / 5 - 1) || Di !== sword(c / 5 - 1)) begin
                    fails++;
                    $display("FAIL stream_word c=%0d got %0d:%h expected %0d:%h", c, Dir, Di, c / 5 - 1, sword(c / 5 - 1));
                end
            end
            if (c % 5 == 1 && c > 1) begin
                tests++;
                if (count !== 6'(c / 5)) begin
                    fails++;
                    $display("FAIL stream_count c=%0d got %0d expected %0d", c, count, c / 5);
                end
            end
            if (c == 160) begin
                tests++;
                if (done !== 1'b0) begin
                    fails++;
                    $display("FAIL stream_done_early got %b expected 0", done);
                end
            end
            if (c == 161) begin
                tests++;
                if ({done, busy, count} !== {1'b1, 1'b0, 6'd32}) begin
                    fails++;
                    $display("FAIL stream_end got done=%b busy=%b count=%0d expected 1 0 32", done, busy, count);
                end
            end
            byte_in = sbyte(c);
            step();
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_restart_from_done();
        logic [7:0] tbl [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        step();
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL restart_pre_done got %b expected 1", done);
        end
        pulse_start();
        tests++;
        if ({done, busy, byte_ready, count} !== {1'b0, 1'b1, 1'b1, 6'd0}) begin
            fails++;
            $display("FAIL restart_state got done=%b busy=%b rdy=%b count=%0d expected 0 1 1 0", done, busy, byte_ready, count);
        end
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_in = tbl[i];
            step();
        end
        byte_valid = 1'b0;
        tests++;
        if ({RegEn, Dir, Di} !== {1'b1, 5'd0, 32'h44332211}) begin
            fails++;
            $display("FAIL restart_word got en=%b %0d:%h expected 1 0:44332211", RegEn, Dir, Di);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests++;
        if ({busy, RegEn, count} !== {1'b0, 1'b0, 6'd1}) begin
            fails++;
            $display("FAIL abort_in_write got busy=%b en=%b count=%0d expected 0 0 1", busy, RegEn, count);
        end
        step();
    endtask

    task automatic test_gapped();
        logic [7:0] tbl [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pulse_start();
        for (int c = 1; c <= 7; c++) begin
            tests++;
            if ({byte_ready, RegEn} !== 2'b10) begin
                fails++;
                $display("FAIL gapped_recv c=%0d got rdy=%b en=%b expected 1 0", c, byte_ready, RegEn);
            end
            byte_valid = (c % 2 == 1);
            byte_in = (c % 2 == 1) ? tbl[c / 2] : 8'h55;
            step();
        end
        byte_valid = 1'b0;
        tests++;
        if ({RegEn, byte_ready, Dir, Di} !== {1'b1, 1'b0, 5'd0, 32'hEFBEADDE}) begin
            fails++;
            $display("FAIL gapped_write got en=%b rdy=%b %0d:%h expected 1 0 0:efbeadde", RegEn, byte_ready, Dir, Di);
        end
        clean_abort();
    endtask

    task automatic test_abort_4th();
        pulse_start();
        byte_valid = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            byte_in = sbyte(c);
            abort = (c == 29);
            step();
        end
        abort = 1'b0;
        byte_valid = 1'b0;
        tests++;
        if ({RegEn, busy, byte_ready, done, count} !== {4'b0000, 6'd5}) begin
            fails++;
            $display("FAIL abort4_state got en=%b busy=%b rdy=%b done=%b count=%0d expected 0 0 0 0 5", RegEn, busy, byte_ready, done, count);
        end
        tests++;
        if (Di !== 32'h13121110) begin
            fails++;
            $display("FAIL abort4_di_hold got %h expected 13121110", Di);
        end
        step();
        pulse_start();
        byte_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            byte_in = 8'hA0 + 8'(i);
            step();
        end
        byte_valid = 1'b0;
        tests++;
        if ({RegEn, Dir, Di} !== {1'b1, 5'd0, 32'hA3A2A1A0}) begin
            fails++;
            $display("FAIL abort4_reload got en=%b %0d:%h expected 1 0:a3a2a1a0", RegEn, Dir, Di);
        end
        clean_abort();
    endtask

    task automatic test_start_ignored();
        pulse_start();
        byte_valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            if (c == 5 || c == 10) begin
                tests++;
                if ({RegEn, Dir, Di} !== {1'b1, 5'(c / 5 - 1), sword(c / 5 - 1)}) begin
                    fails++;
                    $display("FAIL ignored_word c=%0d got en=%b %0d:%h expected 1 %0d:%h", c, RegEn, Dir, Di, c / 5 - 1, sword(c / 5 - 1));
                end
            end
            if (c == 11) begin
                tests++;
                if ({busy, count} !== {1'b1, 6'd2}) begin
                    fails++;
                    $display("FAIL ignored_count got busy=%b count=%0d expected 1 2", busy, count);
                end
            end
            byte_in = sbyte(c);
            start = (c == 3 || c == 7);
            step();
        end
        start = 1'b0;
        clean_abort();
    endtask

    task automatic test_async_reset();
        pulse_start();
        byte_valid = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            byte_in = sbyte(c);
            step();
        end
        tests++;
        if ({RegEn, Dir, Di, count} !== {1'b1, 5'd1, 32'h07060504, 6'd1}) begin
            fails++;
            $display("FAIL areset_pre got en=%b %0d:%h count=%0d expected 1 1:07060504 1", RegEn, Dir, Di, count);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({byte_ready, RegEn, Dir, Di, busy, done, count} !== 47'd0) begin
            fails++;
            $display("FAIL areset_write got %h expected 0", {byte_ready, RegEn, Dir, Di, busy, done, count});
        end
        byte_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        pulse_start();
        byte_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            byte_in = sbyte(c);
            step();
        end
        byte_valid = 1'b0;
        tests++;
        if ({RegEn, Dir, Di} !== {1'b1, 5'd0, 32'h03020100}) begin
            fails++;
            $display("FAIL areset_reload got en=%b %0d:%h expected 1 0:03020100", RegEn, Dir, Di);
        end
        clean_abort();
    endtask

    task automatic test_partial();
        logic wr, rdy;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            wr  = (c % 5 == 0) && (c <= 20);
            rdy = (c % 5 != 0) && (c <= 20);
            tests++;
            if ({RegEn4, byte_ready4} !== {wr, rdy}) begin
                fails++;
                $display("FAIL partial_ctl c=%0d got en=%b rdy=%b expected %b %b", c, RegEn4, byte_ready4, wr, rdy);
            end
            if (wr) begin
                tests++;
                if (Dir4 !== 5'(c / 5 - 1) || Di4 !== sword(c / 5 - 1)) begin
                    fails++;
                    $display("FAIL partial_word c=%0d got %0d:%h expected %0d:%h", c, Dir4, Di4, c / 5 - 1, sword(c / 5 - 1));
                end
            end
            if (c >= 21) begin
                tests++;
                if ({done4, busy4, count4} !== {1'b1, 1'b0, 6'd4}) begin
                    fails++;
                    $display("FAIL partial_done c=%0d got done=%b busy=%b count=%0d expected 1 0 4", c, done4, busy4, count4);
                end
            end
            byte_valid4 = 1'b1;
            byte_in4 = sbyte(c);
            step();
        end
        byte_valid4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_restart_from_done();
        test_gapped();
        test_abort_4th();
        test_start_ignored();
        test_async_reset();
        test_partial();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
